// File: rtl/blink_pwm_pkg.sv
// Purpose: shared types and register map for the blink/PWM LED slot core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package blink_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    // Register offsets within a channel's 4-word window (addr[1:0]).
    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_ON     = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL register layout.
    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_MODE_MSB = 1;
    localparam int CTRL_INV_BIT  = 2;
    localparam int CTRL_W        = 3;

endpackage

// File: rtl/blink_pwm_core_channel.sv
// Purpose: one LED channel - PERIOD/ON_TIME/CTRL registers, phase counter, busy flag, registered led.
// Latency: led follows a register write or tick by 1 clk; registers update on the write edge.
// Backpressure: none; writes and ticks are always accepted.
module blink_channel
    import blink_pwm_pkg::*;
#(
    parameter int TIME_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              wr_period,
    input  logic              wr_on,
    input  logic              wr_ctrl,
    input  logic [TIME_W-1:0] wdata,
    output logic [TIME_W-1:0] period,
    output logic [TIME_W-1:0] on_time,
    output logic [CTRL_W-1:0] ctrl,
    output logic [TIME_W-1:0] phase,
    output logic              busy,
    output logic              state,
    output logic              led
);

    localparam logic [TIME_W-1:0] ONE = {{(TIME_W-1){1'b0}}, 1'b1};

    mode_t             mode;
    logic              inv;
    logic [TIME_W-1:0] phase_nxt;
    logic [TIME_W-1:0] phase_inc;
    logic              busy_nxt;

    assign ctrl      = {inv, mode};
    assign phase_inc = phase + ONE;

    // Raw (pre-invert) channel state from mode, timing registers and phase.
    always_comb begin
        state = 1'b0;
        case (mode)
            MODE_OFF:     state = 1'b0;
            MODE_ON:      state = 1'b1;
            MODE_BLINK:   state = (period != '0) && (phase < on_time);
            MODE_ONESHOT: state = busy && (phase < on_time);
            default:      state = 1'b0;
        endcase
    end

    // Next phase/busy: any register write restarts the channel and beats a same-cycle tick.
    always_comb begin
        phase_nxt = phase;
        busy_nxt  = busy;
        if (wr_period || wr_on) begin
            phase_nxt = '0;
        end else if (wr_ctrl) begin
            phase_nxt = '0;
            busy_nxt  = (mode_t'(wdata[CTRL_MODE_MSB:CTRL_MODE_LSB]) == MODE_ONESHOT);
        end else begin
            case (mode)
                MODE_BLINK: begin
                    if (period == '0) begin
                        phase_nxt = '0;
                    end else if (tick) begin
                        phase_nxt = (phase == period - ONE) ? '0 : phase_inc;
                    end
                end
                MODE_ONESHOT: begin
                    if (busy) begin
                        // ON_TIME of 0 drops busy the cycle after the trigger.
                        if (phase >= on_time) begin
                            busy_nxt = 1'b0;
                        end else if (tick) begin
                            phase_nxt = phase_inc;
                            if (phase_inc == on_time) begin
                                busy_nxt = 1'b0;
                            end
                        end
                    end
                end
                default: phase_nxt = '0;
            endcase
        end
    end

    // Register file, phase/busy state and the registered, optionally inverted led.
    always_ff @(posedge clk) begin
        if (!reset) begin
            period  <= '0;
            on_time <= '0;
            mode    <= MODE_OFF;
            inv     <= 1'b0;
            phase   <= '0;
            busy    <= 1'b0;
            led     <= 1'b0;
        end else begin
            if (wr_period) begin
                period <= wdata;
            end
            if (wr_on) begin
                on_time <= wdata;
            end
            if (wr_ctrl) begin
                mode <= mode_t'(wdata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
                inv  <= wdata[CTRL_INV_BIT];
            end
            phase <= phase_nxt;
            busy  <= busy_nxt;
            led   <= state ^ inv;
        end
    end

endmodule

// File: rtl/blink_pwm_core.sv
// Purpose: MMIO slot core with N_CH blink/PWM/one-shot LED channels and a shared 1 ms prescaler.
// Latency: writes take effect on the write edge, led 1 clk later; rd_data is combinational from addr.
// Backpressure: none; the slot accepts every access.
module blink_pwm_core
    import blink_pwm_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int TICK_DIV = 100000,
    parameter int TIME_W   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cs,
    input  logic            read,
    input  logic            write,
    input  logic [4:0]      addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    output logic [N_CH-1:0] led
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic [2:0]        ch_sel;
    logic [1:0]        reg_sel;
    logic              bus_wr;
    logic              unused_bits;

    logic [TIME_W-1:0] ch_period [N_CH];
    logic [TIME_W-1:0] ch_on     [N_CH];
    logic [CTRL_W-1:0] ch_ctrl   [N_CH];
    logic [TIME_W-1:0] ch_phase  [N_CH];
    logic [N_CH-1:0]   ch_busy;
    logic [N_CH-1:0]   ch_state;

    assign ch_sel      = addr[4:2];
    assign reg_sel     = addr[1:0];
    assign bus_wr      = cs && write;
    assign tick        = (pre_cnt == PRE_LAST);
    // read strobe is not needed (rd_data is always driven); upper data bits have no home.
    assign unused_bits = ^{read, wr_data[31:TIME_W]};

    // Free-running 1 ms prescaler; never restarted by channel writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_ONE;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic sel;
        assign sel = bus_wr && (ch_sel == 3'(i));

        blink_channel #(
            .TIME_W (TIME_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .wr_period (sel && (reg_sel == REG_PERIOD)),
            .wr_on     (sel && (reg_sel == REG_ON)),
            .wr_ctrl   (sel && (reg_sel == REG_CTRL)),
            .wdata     (wr_data[TIME_W-1:0]),
            .period    (ch_period[i]),
            .on_time   (ch_on[i]),
            .ctrl      (ch_ctrl[i]),
            .phase     (ch_phase[i]),
            .busy      (ch_busy[i]),
            .state     (ch_state[i]),
            .led       (led[i])
        );
    end

    // Read mux: channel indices with no channel behind them fall through to 0.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == 3'(i)) begin
                case (reg_sel)
                    REG_PERIOD: rd_data = 32'(ch_period[i]);
                    REG_ON:     rd_data = 32'(ch_on[i]);
                    REG_CTRL:   rd_data = 32'(ch_ctrl[i]);
                    default:    rd_data = {16'(ch_phase[i]), 14'd0, ch_busy[i], ch_state[i]};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blink_pwm_core.sv
// Purpose: scoreboard bench for blink_pwm_core against a tick-counting behavioural model.
// Latency: model predicts led and rd_data after every rising edge; monitor compares 1 ns later.
// Backpressure: n/a.
module tb_blink_pwm_core;

    localparam int N_CH     = 4;
    localparam int TICK_DIV = 10;
    localparam int TIME_W   = 16;

    logic            clk     = 1'b0;
    logic            reset   = 1'b0;
    logic            cs      = 1'b0;
    logic            read    = 1'b0;
    logic            write   = 1'b0;
    logic [4:0]      addr    = '0;
    logic [31:0]     wr_data = '0;
    logic [31:0]     rd_data;
    logic [N_CH-1:0] led;

    blink_pwm_core #(
        .N_CH     (N_CH),
        .TICK_DIV (TICK_DIV),
        .TIME_W   (TIME_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .led     (led)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0]     rd_q  [$];
    logic [4:0]      rda_q [$];
    logic [N_CH-1:0] led_q [$];

    // Model: registers plus, per channel, whole ms ticks and clock edges since its last write.
    int m_period [N_CH];
    int m_on     [N_CH];
    int m_mode   [N_CH];
    int m_inv    [N_CH];
    int m_ticks  [N_CH];
    int m_age    [N_CH];
    int m_pre;

    function automatic int m_phase(input int c);
        case (m_mode[c])
            2:       return (m_period[c] == 0) ? 0 : m_ticks[c] % m_period[c];
            3:       return (m_ticks[c] < m_on[c]) ? m_ticks[c] : m_on[c];
            default: return 0;
        endcase
    endfunction

    function automatic int m_busy(input int c);
        if (m_mode[c] != 3) return 0;
        if (m_on[c] == 0) return (m_age[c] == 0) ? 1 : 0;
        return (m_ticks[c] < m_on[c]) ? 1 : 0;
    endfunction

    function automatic int m_state(input int c);
        case (m_mode[c])
            1:       return 1;
            2:       return (m_period[c] != 0 && m_phase(c) < m_on[c]) ? 1 : 0;
            3:       return (m_ticks[c] < m_on[c]) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        int c;
        logic [15:0] ph;
        c = int'(a[4:2]);
        if (c >= N_CH) return 32'd0;
        ph = 16'(m_phase(c));
        case (a[1:0])
            2'd0:    return 32'(m_period[c]);
            2'd1:    return 32'(m_on[c]);
            2'd2:    return 32'(m_inv[c] * 4 + m_mode[c]);
            default: return {ph, 14'd0, 1'(m_busy(c)), 1'(m_state(c))};
        endcase
    endfunction

    // Model process: advance on each rising edge, push expected led and any read response.
    initial begin : model
        logic [N_CH-1:0] nl;
        bit tk;
        int c;
        m_pre = 0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                for (int i = 0; i < N_CH; i++) begin
                    m_period[i] = 0; m_on[i] = 0; m_mode[i] = 0; m_inv[i] = 0;
                    m_ticks[i] = 0; m_age[i] = 0;
                end
                m_pre = 0;
                led_q.push_back('0);
            end else begin
                for (int i = 0; i < N_CH; i++) nl[i] = 1'(m_state(i) ^ m_inv[i]);
                tk    = (m_pre == TICK_DIV - 1);
                m_pre = tk ? 0 : m_pre + 1;
                c     = int'(addr[4:2]);
                for (int i = 0; i < N_CH; i++) begin
                    if (cs && write && c == i && addr[1:0] != 2'd3) begin
                        case (addr[1:0])
                            2'd0: m_period[i] = int'(wr_data[15:0]);
                            2'd1: m_on[i]     = int'(wr_data[15:0]);
                            default: begin
                                m_mode[i] = int'(wr_data[1:0]);
                                m_inv[i]  = int'(wr_data[2]);
                            end
                        endcase
                        m_ticks[i] = 0;
                        m_age[i]   = 0;
                    end else begin
                        m_age[i] = m_age[i] + 1;
                        if (tk) m_ticks[i] = m_ticks[i] + 1;
                    end
                end
                led_q.push_back(nl);
            end
            if (read) begin
                rd_q.push_back(m_read(addr));
                rda_q.push_back(addr);
            end
        end
    end

    // Monitor: pop expectations and compare against the DUT outputs just after each edge.
    initial begin : monitor
        logic [N_CH-1:0] el;
        logic [31:0]     er;
        logic [4:0]      ea;
        forever begin
            @(posedge clk);
            #1;
            if (led_q.size() > 0) begin
                el = led_q.pop_front();
                checks++;
                if (led !== el) begin
                    failures++;
                    $display("FAIL led t=%0t: got %b expected %b", $time, led, el);
                end
            end
            if (rd_q.size() > 0) begin
                er = rd_q.pop_front();
                ea = rda_q.pop_front();
                checks++;
                if (rd_data !== er) begin
                    failures++;
                    $display("FAIL rd_data addr=%0h t=%0t: got %h expected %h", ea, $time, rd_data, er);
                end
            end
        end
    end

    task automatic bus_wr(input int c, input int r, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; read = 1'b0;
        addr = {c[2:0], r[1:0]}; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic bus_rd(input int c, input int r);
        @(negedge clk);
        cs = 1'b1; read = 1'b1; write = 1'b0;
        addr = {c[2:0], r[1:0]};
        @(negedge clk);
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_all();
        for (int a = 0; a < 32; a++) bus_rd(a / 4, a % 4);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion by t=%0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c, r, op, k;
        logic [31:0] rnd, d;

        // Reset held with writes active.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            cs = 1'b1; write = 1'b1; addr = 5'(j); wr_data = 32'hFFFF_FFFF;
        end
        @(negedge clk);
        cs = 1'b0; write = 1'b0; reset = 1'b1;
        read_all();

        // Ch0 blink 4 ms period, 1 ms on.
        bus_wr(0, 0, 4); bus_wr(0, 1, 1); bus_wr(0, 2, 2);
        repeat (14) begin bus_rd(0, 3); idle(2); end

        // Ch1 on-time beyond period, then period 0.
        bus_wr(1, 0, 3); bus_wr(1, 1, 5); bus_wr(1, 2, 2);
        idle(30); bus_rd(1, 3);
        bus_wr(1, 0, 0); idle(15); bus_rd(1, 3);

        // Ch2 one-shot of 3 ms, retriggered mid-pulse.
        bus_wr(2, 1, 3); bus_wr(2, 2, 3); bus_rd(2, 3);
        idle(12); bus_rd(2, 3);
        bus_wr(2, 2, 3);
        repeat (15) begin bus_rd(2, 3); idle(2); end
        idle(10); bus_rd(2, 3);

        // Ch3 inversion, then out-of-range channel and wide data.
        bus_wr(3, 2, 32'h5); idle(3); bus_rd(3, 3);
        bus_wr(3, 2, 32'h4); idle(3); bus_rd(3, 2);
        bus_wr(5, 0, 32'h1234); bus_wr(5, 2, 32'h2);
        bus_rd(5, 0); bus_rd(5, 2); bus_rd(5, 3);
        bus_wr(3, 0, 32'hABCD_FFFF); bus_rd(3, 0);
        bus_wr(3, 1, 32'h0001_FFFF); bus_rd(3, 1);
        bus_wr(3, 3, 32'hFFFF_FFFF); bus_rd(3, 3);
        bus_wr(3, 1, 0); bus_wr(3, 0, 0);
        read_all();

        // Write ch0 CTRL on the exact tick edge.
        k = 0;
        while (k < 3 * TICK_DIV && m_pre != TICK_DIV - 1) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (m_pre != TICK_DIV - 1) begin
            failures++;
            $display("FAIL tick_align: got prescaler %0d expected %0d", m_pre, TICK_DIV - 1);
        end
        cs = 1'b1; write = 1'b1; addr = {3'd0, 2'd2}; wr_data = 32'h2;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
        bus_rd(0, 3);

        // Randomised traffic.
        repeat (300) begin
            c  = $urandom_range(0, 7);
            op = $urandom_range(0, 3);
            if (op == 0) begin
                bus_rd(c, $urandom_range(0, 3));
            end else if (op == 3) begin
                idle($urandom_range(1, 25));
            end else begin
                r = $urandom_range(0, 3);
                if (c < N_CH && m_mode[c] == 3) r = 2;
                rnd = $urandom;
                case (r)
                    0:       d = {rnd[31:16], 16'($urandom_range(0, 6))};
                    1:       d = {rnd[31:16], 16'($urandom_range(0, 8))};
                    default: d = rnd;
                endcase
                bus_wr(c, r, d);
            end
        end

        // Reset in the middle of a blink.
        bus_wr(0, 0, 4); bus_wr(0, 1, 2); bus_wr(0, 2, 2);
        idle(17);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        read_all();

        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blink_pwm_core.md
Name: blink_pwm_core

Overview:
- Parametrised MMIO slot core driving N_CH independent LED channels.
- Each channel has a programmable period and on-time in milliseconds, a mode, an output inversion bit and a readable status word.
- Sits on the processor bus slot interface (cs/read/write/addr/wr_data/rd_data) like the other I/O cores.
- Replaces fixed 50% blinking with duty control, forced on/off, one-shot pulses and full readback.

Parameters:
- N_CH, 4, number of LED channels (1..8).
- TICK_DIV, 100000, clk cycles per 1 ms tick (100 MHz system clock).
- TIME_W, 16, width of the period and on-time registers, in ms units.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- cs  in  1  slot select.
- read  in  1  bus read strobe (rd_data is valid regardless).
- write  in  1  bus write strobe.
- addr  in  5  word address: addr[4:2] = channel, addr[1:0] = register.
- wr_data  in  32  write data.
- rd_data  out  32  read data.
- led  out  N_CH  LED outputs, registered.

Behaviour:
- Register map per channel:
  - 0 PERIOD: TIME_W bits, R/W.
  - 1 ON_TIME: TIME_W bits, R/W.
  - 2 CTRL: bits[1:0] mode, bit2 invert, R/W.
  - 3 STATUS, read-only:
    - bit0 = raw channel state before invert
    - bit1 = busy
    - bits[31:16] = phase
- Writes occur when cs && write on a rising clk. Unused upper wr_data bits are ignored.
- Channel index >= N_CH: writes are ignored, reads return 0. Writes to STATUS are ignored.
- rd_data is combinational from addr. Unused bits read 0.
- Reset (reset==0 at a rising clk): every register, phase counter, busy flag and the prescaler clear to 0. led = 0. Reset mid-pulse aborts the pulse.
- Prescaler: one shared, free-running counter 0..TICK_DIV-1. tick is high for 1 cycle when the count reaches TICK_DIV-1.
- Modes:
  - 0 OFF: state = 0, phase held at 0.
  - 1 ON: state = 1, phase held at 0.
  - 2 BLINK:
    - On tick, phase = (phase == PERIOD-1) ? 0 : phase+1.
    - state = (phase < ON_TIME).
    - PERIOD == 0: state = 0, phase held at 0.
    - ON_TIME >= PERIOD: state = 1.
    - ON_TIME == 0: state = 0.
  - 3 ONESHOT:
    - A write to CTRL with mode = 3 sets busy = 1 and phase = 0.
    - While busy, phase increments on tick. state = (phase < ON_TIME).
    - When phase reaches ON_TIME, busy = 0 and phase is held.
    - ON_TIME == 0: busy clears on the cycle after the write.
    - Retrigger is done by rewriting CTRL; a rewrite mid-pulse restarts from phase 0.
- Any write to PERIOD, ON_TIME or CTRL of a channel resets that channel's phase to 0 on the same clock edge.
- Prescaler is not restarted on channel writes. The first ms after a restart therefore lasts 1..TICK_DIV cycles. Jitter below 1 ms is accepted.
- led[i] = state_i ^ invert_i, registered. led updates 1 cycle after the state change (write or tick).
- Simultaneous tick and write to the same channel: the write wins, and phase = 0.
- Arithmetic: phase is TIME_W bits and compares are unsigned. PERIOD = 2^TIME_W-1 must wrap cleanly.

Decomposition:
- Package blink_pwm_pkg:
  - mode enum {MODE_OFF, MODE_ON, MODE_BLINK, MODE_ONESHOT}.
  - Register offset constants REG_PERIOD, REG_ON, REG_CTRL, REG_STATUS.
  - CTRL bit positions.
- Sub-module blink_channel, instantiated N_CH times via generate:
  - Holds PERIOD, ON_TIME, CTRL, phase, busy and the registered led output.
  - Inputs: tick, write strobes per register, wr_data.
- The top level holds the prescaler, address decode and read mux.

Test Plan (N_CH=4, TICK_DIV=10, TIME_W=16):
- Reset: hold reset=0 for 3 cycles with writes active -> led=0; every register and STATUS read 0.
- Ch0 BLINK with PERIOD=4, ON_TIME=1 -> led[0] high 10 cycles, low 30 cycles, repeating. STATUS phase cycles 0,1,2,3,0.
- Ch1 BLINK with ON_TIME=5 >= PERIOD=3 -> led[1] constant 1. Then PERIOD=0 -> led[1]=0 and phase=0.
- Ch2 ONESHOT with ON_TIME=3 -> busy=1, led[2]=1 one cycle after the write. After 3 ticks busy=0 and led[2]=0 and stays 0. A retrigger at phase 1 extends the pulse to 3 further ticks.
- Ch3 mode ON with invert=1 -> led[3]=0. Mode OFF with invert=1 -> led[3]=1. Write addr channel 5 -> no state change, read returns 0.
- Write to ch0 CTRL on the exact tick cycle -> phase=0 the next cycle (write wins). Assert reset=0 mid-blink -> led=0 the next cycle and all registers 0.
